// File: rtl/morse_pkg.sv
// Shared definitions for the Morse key timer: FSM state encoding and the
// timing thresholds, expressed in Morse units.
package morse_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MARK    = 2'd1,
        S_GAP     = 2'd2,
        S_CHARGAP = 2'd3
    } state_t;

    localparam int DASH_UNITS = 2;
    localparam int CHAR_UNITS = 2;
    localparam int WORD_UNITS = 5;
    localparam int SAT_UNITS  = 7;

    // Counter width able to hold the saturated mark length.
    function automatic int cnt_width(input int unit_cycles);
        return $clog2(SAT_UNITS * unit_cycles + 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Level debouncer: output follows input only after DEBOUNCE_CYCLES consecutive
// samples at the new level, so both edges are delayed by DEBOUNCE_CYCLES.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/morse_key_timer.sv
// Morse key timer: classifies key marks into dot/dash and gaps into char/word
// spaces as one-cycle pulses. Optional debounce via MORSE_KEY_DEBOUNCE_EN.
module morse_key_timer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic dot_out,
    output logic dash_out,
    output logic char_space_out,
    output logic word_space_out
);

    localparam int CW = cnt_width(UNIT_CYCLES);
    localparam logic [CW-1:0] DASH_MIN  = CW'(DASH_UNITS * UNIT_CYCLES);
    localparam logic [CW-1:0] CHAR_LAST = CW'(CHAR_UNITS * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] WORD_LAST = CW'(WORD_UNITS * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] SAT_MAX   = CW'(SAT_UNITS * UNIT_CYCLES);
    localparam logic [CW-1:0] CNT_FIRST = CW'(1);

    generate
        if (UNIT_CYCLES < 2 || UNIT_CYCLES > 65535 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
            $error("morse_key_timer: parameter out of range");
        end
    endgenerate

    logic   sync_q1;
    logic   sync_q2;
    logic   key_clean;
    state_t state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= key_in;
            sync_q2 <= sync_q1;
        end
    end

`ifdef MORSE_KEY_DEBOUNCE_EN
    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (sync_q2),
        .dout (key_clean)
    );
`else
    assign key_clean = sync_q2;
`endif

    // cnt holds the number of samples already seen in the current interval;
    // the transition sample itself is the first, hence loads of CNT_FIRST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            dot_out        <= 1'b0;
            dash_out       <= 1'b0;
            char_space_out <= 1'b0;
            word_space_out <= 1'b0;
        end else begin
            dot_out        <= 1'b0;
            dash_out       <= 1'b0;
            char_space_out <= 1'b0;
            word_space_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (key_clean) begin
                        state <= S_MARK;
                        cnt   <= CNT_FIRST;
                    end
                end
                S_MARK: begin
                    if (key_clean) begin
                        if (cnt != SAT_MAX) cnt <= cnt + 1'b1;
                    end else begin
                        if (cnt < DASH_MIN) dot_out  <= 1'b1;
                        else                dash_out <= 1'b1;
                        state <= S_GAP;
                        cnt   <= CNT_FIRST;
                    end
                end
                S_GAP: begin
                    if (key_clean) begin
                        state <= S_MARK;
                        cnt   <= CNT_FIRST;
                    end else begin
                        if (cnt == CHAR_LAST) begin
                            char_space_out <= 1'b1;
                            state          <= S_CHARGAP;
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CHARGAP: begin
                    if (key_clean) begin
                        state <= S_MARK;
                        cnt   <= CNT_FIRST;
                    end else if (cnt == WORD_LAST) begin
                        word_space_out <= 1'b1;
                        state          <= S_IDLE;
                        cnt            <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_key_timer.sv
// Bench for morse_key_timer: run-length reference model of the key level
// checked every cycle, plus directed scenarios with literal pulse counts/timing.
module tb_morse_key_timer;

    localparam int U  = 4;
    localparam int DB = 8;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic key_in = 1'b0;
    logic dot_out, dash_out, char_space_out, word_space_out;

    morse_key_timer #(
        .UNIT_CYCLES     (U),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .key_in         (key_in),
        .dot_out        (dot_out),
        .dash_out       (dash_out),
        .char_space_out (char_space_out),
        .word_space_out (word_space_out)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: key level as seen by the timer, and run lengths of it.
    logic h1 = 1'b0, h2 = 1'b0, m_kc = 1'b0, prev_kc = 1'b0, had_mark = 1'b0;
    int   hi_len = 0, lo_len = 0;
`ifdef MORSE_KEY_DEBOUNCE_EN
    logic m_db = 1'b0;
    int   m_dc = 0;
`endif
    logic [3:0] exp_o;

    int n_dot = 0, n_dash = 0, n_char = 0, n_word = 0;
    int t_dot = 0, t_dash = 0, t_char = 0, t_word = 0;

    always @(posedge clk) begin
        cyc++;
        exp_o = 4'b0000;
        if (!rst) begin
            h1 = 1'b0; h2 = 1'b0; prev_kc = 1'b0; had_mark = 1'b0;
            hi_len = 0; lo_len = 0;
`ifdef MORSE_KEY_DEBOUNCE_EN
            m_db = 1'b0; m_dc = 0;
`endif
        end else begin
`ifdef MORSE_KEY_DEBOUNCE_EN
            m_kc = m_db;
            if (h2 != m_db) begin
                m_dc++;
                if (m_dc == DB) begin
                    m_db = h2;
                    m_dc = 0;
                end
            end else begin
                m_dc = 0;
            end
`else
            m_kc = h2;
`endif
            h2 = h1;
            h1 = key_in;
            if (m_kc) begin
                hi_len = prev_kc ? hi_len + 1 : 1;
            end else begin
                if (prev_kc) begin
                    exp_o    = (hi_len < 2 * U) ? 4'b1000 : 4'b0100;
                    lo_len   = 1;
                    had_mark = 1'b1;
                end else begin
                    lo_len++;
                end
                if (had_mark && lo_len == 2 * U) exp_o = 4'b0010;
                if (had_mark && lo_len == 5 * U) exp_o = 4'b0001;
            end
            prev_kc = m_kc;
        end
        #1;
        vectors++;
        if ({dot_out, dash_out, char_space_out, word_space_out} !== exp_o) begin
            miscompares++;
            $display("FAIL cycle_outputs cyc=%0d got %b want %b", cyc,
                     {dot_out, dash_out, char_space_out, word_space_out}, exp_o);
        end
        if (dot_out)        begin n_dot++;  t_dot  = cyc; end
        if (dash_out)       begin n_dash++; t_dash = cyc; end
        if (char_space_out) begin n_char++; t_char = cyc; end
        if (word_space_out) begin n_word++; t_word = cyc; end
    end

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic clr();
        n_dot = 0; n_dash = 0; n_char = 0; n_word = 0;
    endtask

    task automatic hold(input logic v, input int n);
        key_in = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic k;
        // Reset held while the key toggles, then idle with key low.
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            key_in = (i % 2 == 0);
            @(negedge clk);
        end
        check("reset_outputs", int'({dot_out, dash_out, char_space_out, word_space_out}), 0);
        key_in = 1'b0;
        rst = 1'b1;
        clr();
        hold(1'b0, 200);
        check("idle_no_pulse", n_dot + n_dash + n_char + n_word, 0);

        // Single dot with char and word spaces.
        clr();
        hold(1'b1, 4);
        hold(1'b0, 40);
        check("dot4_dot", n_dot, 1);
        check("dot4_dash", n_dash, 0);
        check("dot4_char", n_char, 1);
        check("dot4_word", n_word, 1);
        check("char_after_dot", t_char - t_dot, 7);
        check("word_after_dot", t_word - t_dot, 19);

        // Dot/dash boundary and saturation.
        clr();
        hold(1'b1, 7);
        hold(1'b0, 40);
        check("mark7_dot", n_dot, 1);
        check("mark7_dash", n_dash, 0);
        clr();
        hold(1'b1, 8);
        hold(1'b0, 40);
        check("mark8_dash", n_dash, 1);
        check("mark8_dot", n_dot, 0);
        clr();
        hold(1'b1, 1000);
        hold(1'b0, 40);
        check("mark1000_dash", n_dash, 1);
        check("mark1000_dot", n_dot, 0);
        check("mark1000_word", n_word, 1);

        // Dot, short gap, dash: no space between elements.
        clr();
        hold(1'b1, 4);
        hold(1'b0, 4);
        hold(1'b1, 8);
        hold(1'b0, 40);
        check("elem_dot", n_dot, 1);
        check("elem_dash", n_dash, 1);
        check("elem_char", n_char, 1);
        check("elem_word", n_word, 1);
        check("elem_char_after_dash", t_char - t_dash, 7);

        // Key rise on the char-space threshold cycle wins.
        clr();
        hold(1'b1, 4);
        hold(1'b0, 7);
        hold(1'b1, 4);
        check("rise_at_thresh_char", n_char, 0);
        hold(1'b0, 40);
        check("rise_at_thresh_dots", n_dot, 2);
        check("rise_at_thresh_char_end", n_char, 1);

        // Reset mid-mark discards the measurement.
        clr();
        hold(1'b1, 8);
        rst = 1'b0;
        hold(1'b1, 3);
        rst = 1'b1;
        hold(1'b1, 2);
        hold(1'b0, 40);
        check("rst_mid_mark_dot", n_dot, 1);
        check("rst_mid_mark_dash", n_dash, 0);

`ifdef MORSE_KEY_DEBOUNCE_EN
        clr();
        hold(1'b0, 30);
        hold(1'b1, 3);
        hold(1'b0, 40);
        check("glitch_no_output", n_dot + n_dash + n_char + n_word, 0);
        clr();
        hold(1'b1, 12);
        hold(1'b0, 60);
        check("debounced_dash", n_dash, 1);
        check("debounced_dot", n_dot, 0);
`endif

        // Random key activity with occasional resets.
        k = 1'b0;
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                rst = 1'b1;
            end
            k = ~k;
            hold(k, $urandom_range(1, 24));
        end
        hold(1'b0, 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/morse_key_timer.md
MORSE_KEY_TIMER -- requirements
Module: morse_key_timer

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 1000, meaning clk cycles per Morse time unit (legal range 2..65535).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning stable-sample count needed to accept a key level change (used only under REQ-020).
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port key_in  input  1  raw asynchronous Morse key, 1 = pressed.
REQ-006 SHALL have ports dot_out, dash_out, char_space_out, word_space_out  output  1 each  registered one-cycle pulses feeding the symbol translator FSM.

Function
REQ-007 SHALL pass key_in through a 2-flop synchronizer; key_clean is the synchronized (and, under REQ-020, debounced) level, and all timing SHALL be measured on key_clean.
REQ-008 SHALL implement FSM states S_IDLE, S_MARK, S_GAP and S_CHARGAP.
REQ-009 S_IDLE: key_clean rise -> S_MARK with cycle counter cleared; no gap pulses are ever produced from S_IDLE.
REQ-010 S_MARK: count cycles with key_clean high; counter SHALL saturate at 7*UNIT_CYCLES and never wrap.
REQ-011 On key_clean fall in S_MARK: if mark length < 2*UNIT_CYCLES, pulse dot_out, else pulse dash_out (exactly 2*UNIT_CYCLES = dash); pulse SHALL occur the cycle after the fall; next state S_GAP, counter cleared.
REQ-012 S_GAP: when key_clean has been low for 2*UNIT_CYCLES cycles, pulse char_space_out once and go to S_CHARGAP.
REQ-013 S_CHARGAP: when total gap reaches 5*UNIT_CYCLES cycles, pulse word_space_out once and go to S_IDLE.
REQ-014 key_clean rise in S_GAP or S_CHARGAP SHALL go to S_MARK with no space pulse; if the rise coincides with a threshold cycle, the rise wins and no space pulse is emitted.
REQ-015 At most one output SHALL be high in any cycle; each pulse SHALL be exactly one cycle wide.
REQ-016 Gap shorter than 2*UNIT_CYCLES (inter-element space) SHALL produce no output.

Reset
REQ-017 rst low SHALL asynchronously force state S_IDLE, all counters, synchronizer and debounce flops to 0, and all four outputs to 0.
REQ-018 Reset asserted mid-mark or mid-gap SHALL discard the measurement; after release, a key still held SHALL be treated as a new press starting from S_IDLE.
REQ-019 After reset release, key held low indefinitely SHALL produce no pulses.

Configuration
REQ-020 With macro MORSE_KEY_DEBOUNCE_EN defined, key_clean SHALL change only after the synchronized key has held a new level for DEBOUNCE_CYCLES consecutive cycles (adds DEBOUNCE_CYCLES latency to both edges).
REQ-021 Without MORSE_KEY_DEBOUNCE_EN, key_clean SHALL equal the 2-flop synchronizer output and no debounce logic SHALL be present.

Structure
REQ-022 Shared package morse_pkg SHALL hold FSM state encoding and the unit-threshold constants DASH_UNITS=2, CHAR_UNITS=2, WORD_UNITS=5, SAT_UNITS=7.
REQ-023 Debounce logic SHALL be a sub-module key_debounce (parameter DEBOUNCE_CYCLES), instantiated only under MORSE_KEY_DEBOUNCE_EN.
REQ-024 Counter width SHALL be derived from 7*UNIT_CYCLES via clog2.

Verification (UNIT_CYCLES=4, debounce off unless stated)
REQ-025 rst low 10 cycles, key_in toggling -> all outputs 0 throughout; release with key low 200 cycles -> no pulses.
REQ-026 key high 4 cycles then low 40 -> one dot_out pulse; char_space_out 8 cycles after key_clean fall; word_space_out 20 cycles after fall; nothing further.
REQ-027 key high 7 cycles -> dot_out; key high 8 cycles -> dash_out; key high 1000 cycles -> single dash_out on release, no wrap.
REQ-028 dot, low 4 cycles, dash, low 40 -> dot_out, dash_out, then char_space_out, word_space_out; no space pulse between elements; key rise exactly at gap cycle 8 -> no char_space_out.
REQ-029 MORSE_KEY_DEBOUNCE_EN, DEBOUNCE_CYCLES=8: 3-cycle glitch high -> no output; clean 12-cycle press -> one dash_out.
REQ-030 rst asserted at mark cycle 6 and released with key still high 2 cycles, then key low -> dot_out only, no dash_out.
